// File: rtl/tdm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_pkg : shared types and constants for the TDM demultiplexer     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int NUM_CH_DEFAULT = 8;
    localparam int SLOT_W         = $clog2(NUM_CH_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_slot_counter : modulo-NUM_CH slot counter, load-to-1 and clear |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_en,
    input  logic                      i_load1,
    input  logic                      i_clr,
    output logic [$clog2(NUM_CH)-1:0] o_count,
    output logic                      o_last
);

    localparam int c_SW = $clog2(NUM_CH);

    logic [c_SW-1:0] r_count;
    logic            w_last;

    assign w_last = (r_count == c_SW'(NUM_CH - 1));

    // Clear wins over load, load wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= c_SW'(1);
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + c_SW'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = w_last;

endmodule
`default_nettype wire

// File: rtl/tdm_demux_1to8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdm_demux_1to8 : serial slot stream to atomic parallel frame       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tdm_demux_1to8
    import tdm_pkg::*;
#(
    parameter int DATA_W       = 1,
    parameter int NUM_CH       = NUM_CH_DEFAULT,
    parameter bit REQUIRE_SYNC = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          din,
    input  logic                       din_valid,
    input  logic                       sync,
    output logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       frame_valid,
    output logic                       locked,
    output logic [$clog2(NUM_CH)-1:0]  slot,
    output logic                       sync_err
);

    localparam int c_SW = $clog2(NUM_CH);
    localparam int c_FW = NUM_CH * DATA_W;

    state_t          r_state, w_state_nxt;
    logic [c_FW-1:0] r_shadow, w_shadow_nxt;
    logic [c_FW-1:0] r_ch_data;
    logic            r_frame_valid, w_fv_nxt;
    logic            r_sync_err, w_err_nxt;
    logic [c_SW-1:0] w_slot, w_wr_idx;
    logic            w_last, w_wr, w_done;
    logic            w_cnt_en, w_cnt_load, w_cnt_clr;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH)
    ) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_cnt_en),
        .i_load1 (w_cnt_load),
        .i_clr   (w_cnt_clr),
        .o_count (w_slot),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wr_idx    = w_slot;
        w_done      = 1'b0;
        w_cnt_en    = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_fv_nxt    = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            HUNT: begin
                if (din_valid && sync) begin
                    w_wr        = 1'b1;
                    w_wr_idx    = '0;
                    w_cnt_load  = 1'b1;
                    w_state_nxt = LOCK;
                end
            end
            LOCK: begin
                if (din_valid) begin
                    if (sync && (w_slot != '0)) begin
                        // Early sync: drop the partial frame and restart at slot 0.
                        w_err_nxt  = 1'b1;
                        w_wr       = 1'b1;
                        w_wr_idx   = '0;
                        w_cnt_load = 1'b1;
                    end else if (REQUIRE_SYNC && !sync && (w_slot == '0)) begin
                        w_err_nxt   = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = HUNT;
                    end else begin
                        w_wr     = 1'b1;
                        w_cnt_en = 1'b1;
                        w_done   = w_last;
                        w_fv_nxt = w_last;
                    end
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_wr) begin
            w_shadow_nxt[int'(w_wr_idx)*DATA_W +: DATA_W] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_shadow      <= '0;
            r_ch_data     <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shadow      <= w_shadow_nxt;
            r_frame_valid <= w_fv_nxt;
            r_sync_err    <= w_err_nxt;
            if (w_done) begin
                r_ch_data <= w_shadow_nxt;
            end
        end
    end

    assign ch_data     = r_ch_data;
    assign frame_valid = r_frame_valid;
    assign sync_err    = r_sync_err;
    assign locked      = (r_state == LOCK);
    assign slot        = w_slot;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1to8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tdm_demux_1to8 : directed vector bench for tdm_demux_1to8       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_tdm_demux_1to8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [0:0] din;
    logic       din_valid;
    logic       sync;
    logic [7:0] ch_data;
    logic       frame_valid;
    logic       locked;
    logic [2:0] slot;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic       s;
        logic       d;
        logic       fv;
        logic       err;
        logic       lk;
        logic [2:0] sl;
        logic [7:0] ch;
    } vec_t;

    vec_t vecs[$];

    tdm_demux_1to8 #(
        .DATA_W       (1),
        .NUM_CH       (8),
        .REQUIRE_SYNC (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .locked      (locked),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic fv, input logic err,
                           input logic lk, input logic [2:0] sl, input logic [7:0] ch);
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(fv));
        chk({tag, ".sync_err"},    32'(sync_err),    32'(err));
        chk({tag, ".locked"},      32'(locked),      32'(lk));
        chk({tag, ".slot"},        32'(slot),        32'(sl));
        chk({tag, ".ch_data"},     32'(ch_data),     32'(ch));
    endtask

    // Present one cycle of input, then sample just after the capturing edge.
    task automatic step(input logic v, input logic s, input logic d);
        @(negedge clk);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic s, input logic d, input logic fv,
                       input logic err, input logic lk, input logic [2:0] sl,
                       input logic [7:0] ch);
        vec_t e;
        e.v = v; e.s = s; e.d = d; e.fv = fv; e.err = err; e.lk = lk; e.sl = sl; e.ch = ch;
        vecs.push_back(e);
    endtask

    initial begin
        logic [7:0] bits;

        // Frame 1: 1,0,1,1,0,0,1,0 -> 8'b01001101
        add(1,1,1, 0,0,1,3'd1, 8'h00);
        add(1,0,0, 0,0,1,3'd2, 8'h00);
        add(1,0,1, 0,0,1,3'd3, 8'h00);
        add(1,0,1, 0,0,1,3'd4, 8'h00);
        add(1,0,0, 0,0,1,3'd5, 8'h00);
        add(1,0,0, 0,0,1,3'd6, 8'h00);
        add(1,0,1, 0,0,1,3'd7, 8'h00);
        add(1,0,0, 1,0,1,3'd0, 8'b01001101);
        add(0,1,1, 0,0,1,3'd0, 8'b01001101);
        // Frame 2 with idles: 0,1,1,0,1,0,0,1 -> 8'b10010110
        add(1,1,0, 0,0,1,3'd1, 8'b01001101);
        add(1,0,1, 0,0,1,3'd2, 8'b01001101);
        add(1,0,1, 0,0,1,3'd3, 8'b01001101);
        add(0,0,0, 0,0,1,3'd3, 8'b01001101);
        add(0,1,1, 0,0,1,3'd3, 8'b01001101);
        add(1,0,0, 0,0,1,3'd4, 8'b01001101);
        add(1,0,1, 0,0,1,3'd5, 8'b01001101);
        add(1,0,0, 0,0,1,3'd6, 8'b01001101);
        add(0,0,1, 0,0,1,3'd6, 8'b01001101);
        add(0,0,0, 0,0,1,3'd6, 8'b01001101);
        add(0,0,1, 0,0,1,3'd6, 8'b01001101);
        add(1,0,0, 0,0,1,3'd7, 8'b01001101);
        add(1,0,1, 1,0,1,3'd0, 8'b10010110);
        // Early sync at slot 5 aborts, then frame 0,1,0,0,0,0,0,1 -> 8'b10000010
        add(1,1,1, 0,0,1,3'd1, 8'b10010110);
        add(1,0,1, 0,0,1,3'd2, 8'b10010110);
        add(1,0,1, 0,0,1,3'd3, 8'b10010110);
        add(1,0,1, 0,0,1,3'd4, 8'b10010110);
        add(1,0,1, 0,0,1,3'd5, 8'b10010110);
        add(1,1,0, 0,1,1,3'd1, 8'b10010110);
        add(1,0,1, 0,0,1,3'd2, 8'b10010110);
        add(1,0,0, 0,0,1,3'd3, 8'b10010110);
        add(1,0,0, 0,0,1,3'd4, 8'b10010110);
        add(1,0,0, 0,0,1,3'd5, 8'b10010110);
        add(1,0,0, 0,0,1,3'd6, 8'b10010110);
        add(1,0,0, 0,0,1,3'd7, 8'b10010110);
        add(1,0,1, 1,0,1,3'd0, 8'b10000010);
        // Missing sync at slot 0 drops lock; later sync-less beats ignored
        add(1,0,1, 0,1,0,3'd0, 8'b10000010);
        add(1,0,1, 0,0,0,3'd0, 8'b10000010);
        add(1,0,0, 0,0,0,3'd0, 8'b10000010);
        add(0,1,1, 0,0,0,3'd0, 8'b10000010);

        rst_n = 1'b0; din_valid = 1'b0; sync = 1'b0; din = 1'b0;
        #3;
        chk_all("reset", 0, 0, 0, 3'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].s, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].fv, vecs[i].err, vecs[i].lk,
                    vecs[i].sl, vecs[i].ch);
        end

        // Hunt from reset: sync-less beats change nothing, then acquire.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1);
            chk_all($sformatf("hunt%0d", i), 0, 0, 0, 3'd0, 8'h00);
        end
        bits = 8'h80;
        for (int i = 0; i < 8; i++) begin
            step(1, (i == 0), bits[i]);
        end
        chk_all("acquire", 1, 0, 1, 3'd0, 8'h80);
        step(0, 0, 0);
        chk_all("acquire_idle", 0, 0, 1, 3'd0, 8'h80);

        // Asynchronous reset with the counter at slot 4.
        for (int i = 0; i < 4; i++) begin
            step(1, (i == 0), 1);
        end
        chk("pre_rst.slot", 32'(slot), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 3'd0, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        bits = 8'h02;
        for (int i = 0; i < 8; i++) begin
            step(1, (i == 0), bits[i]);
        end
        chk_all("post_rst", 1, 0, 1, 3'd0, 8'h02);
        step(0, 0, 0);
        chk_all("post_rst_idle", 0, 0, 1, 3'd0, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
